z80_rf_banked: RTL
==================

# z80_rf_banked

Parametrised successor to the Z80 micro-op register file. Holds the architected Z80 registers, the T0–T3 temporaries and both banks of AF/BC/DE/HL. It serves NUM_RD independent read ports with same-cycle write forwarding. Bank exchanges (EX AF,AF' / EXX / EX DE,HL) are single-cycle pointer flips or swaps rather than copy micro-ops, and R auto-increments on opcode fetch. Sits between the micro-op decoder (read/write ids) and the ALU/address unit, driven by the existing uISA register-id encoding.

## Interface
- NUM_RD, default 2: number of read ports, 1–4.
- SP_RESET, default 16'hDFF0: SP value after reset.
- IDX_RESET, default 16'hFFFF: IX and IY value after reset.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset. One clock; reset is asynchronous and active-low.
- Rd_id  in  5*NUM_RD  read register ids; port k uses bits [5k+4:5k].
- Rd_data  out  16*NUM_RD  read data; port k uses bits [16k+15:16k].
- Wr_en  in  1  register write enable.
- Wr_id  in  5  write register id (uISA encoding).
- Wr_data  in  16  write data.
- Fmask  in  8  per-bit flag write mask.
- F_data  in  8  flag write data.
- Swap_af  in  1  EX AF,AF': toggle the AF bank at the clock edge.
- Swap_main  in  1  EXX: toggle the BC/DE/HL bank at the clock edge.
- Ex_dehl  in  1  EX DE,HL on the active main bank.
- R_inc  in  1  M1 fetch strobe: R[6:0] increments, R[7] is held.
- Bank_af  out  1  current AF bank select; reset 0.
- Bank_main  out  1  current main bank select; reset 0.

## Operation
- Storage:
  - Two physical AF, BC, DE and HL sets (8-bit halves).
  - I, R, SP, IX, IY, and T0–T3.
  - Bank_af and Bank_main flip-flops.
- Id mapping uses the existing uISA ids.
  - A/F/B/C/D/E/H/L and AF/BC/DE/HL address the active bank.
  - AFs/BCs/DEs/HLs address the inactive bank, as 16-bit values.
- Read width rules:
  - 8-bit ids return the value sign-extended to 16 bits.
  - Pair ids return {high, low}.
  - R0 returns 0.
  - Unused ids return 16'h0000, never X.
- Next-state evaluation order within one cycle:
  1. Flag merge: F = (F & ~Fmask) | (F_data & Fmask) on the active F.
  2. Register write if Wr_en. A write to F or AF overrides the flag merge on all 8 F bits.
  3. R_inc, skipped if the same cycle writes R.
  4. Ex_dehl swaps the post-write DE and HL of the active main bank.
  5. Swap_af and Swap_main toggle their bank flags.
- All three exchange strobes may be asserted together.
  - Ex_dehl uses the pre-toggle main bank.
- An 8-bit write to half of a pair updates only that half.
- A 16-bit write to a pair updates both halves.
- R increment arithmetic: R = {R[7], R[6:0]+1}. It wraps 7F→00 within bits [6:0], with R[7] unchanged.
- Reset values:
  - A=00, F=40 in both banks, all other 8-bit registers 0.
  - Shadow pairs 0, SP=SP_RESET, IX=IY=IDX_RESET.
  - Bank flags 0.
  - Rd_data reflects these values combinationally while RST_N is low.
  - Reset overrides all strobes.
- Reset mid-operation: asserting RST_N low restores all reset values immediately, regardless of clock or pending strobes. The first rising CLK after deassertion samples inputs normally.

## Timing
- Reads are purely combinational; latency 0.
- Writes and flag merges commit at the rising CLK edge.
- With forwarding enabled, a read of the id being written in the same cycle returns post-write/post-flag-merge data.
  - Partial overlaps are forwarded too: reading HL while writing L gives {H_old, L_new}.
- Exchange strobes, R_inc and bank toggles are never forwarded. Same-cycle reads see the pre-exchange mapping and the pre-increment R.
- No handshake: every strobe is a single-cycle pulse and is sampled each edge. Holding Swap_af high for N cycles toggles it N times.

## Configuration
- RF_BYPASS_EN defined: same-cycle write and flag forwarding to all read ports, as described in Timing.
- RF_BYPASS_EN undefined: reads return registered state only. Written data is visible from the cycle after the commit edge. The decoder inserts the extra cycle.

## Test plan
- Reset then read all ids: F reads 0040, SP reads DFF0, IX/IY read FFFF, unused id reads 0000, Bank_af=Bank_main=0.
- Write BC=1234, pulse Swap_main, write BC=ABCD. Expected: BC reads ABCD, BCs reads 1234, Bank_main=1. Pulse again: BC reads 1234.
- With RF_BYPASS_EN: write L=0x85 with Rd_id0=HL, Rd_id1=L in the same cycle. Expected: {H_old,85} and FF85 before the edge.
- Fmask=0xC1, F_data=0xFF, plus Wr AF=0x1200 in the same cycle. Expected: next F=00, A=12.
- R=0x7F: pulse R_inc, expect R=0x00. With R=0xFF, expect R=0x80. R_inc together with a write of R=0x10: expect R=0x10.
- DE=1111, HL=2222: assert Ex_dehl+Swap_main+Swap_af together. Expected: DEs=2222, HLs=1111, both bank flags 1. Drop RST_N mid-sequence: all reset values restored immediately.

Source files
------------

// File: rtl/z80_rf_banked.sv
// rtl/z80_rf_banked.sv - Banked Z80 micro-op register file with single-cycle exchanges
// Optional same-cycle write/flag forwarding to the read ports: define RF_BYPASS_EN.
module z80_rf_banked #(
  parameter int          NUM_RD    = 2,
  parameter logic [15:0] SP_RESET  = 16'hDFF0,
  parameter logic [15:0] IDX_RESET = 16'hFFFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [5*NUM_RD-1:0]   i_rd_id,
  output logic [16*NUM_RD-1:0]  o_rd_data,
  input  logic                  i_wr_en,
  input  logic [4:0]            i_wr_id,
  input  logic [15:0]           i_wr_data,
  input  logic [7:0]            i_fmask,
  input  logic [7:0]            i_f_data,
  input  logic                  i_swap_af,
  input  logic                  i_swap_main,
  input  logic                  i_ex_dehl,
  input  logic                  i_r_inc,
  output logic                  o_bank_af,
  output logic                  o_bank_main
);

  localparam logic [4:0] ID_R0  = 5'd0;
  localparam logic [4:0] ID_A   = 5'd1;
  localparam logic [4:0] ID_F   = 5'd2;
  localparam logic [4:0] ID_B   = 5'd3;
  localparam logic [4:0] ID_C   = 5'd4;
  localparam logic [4:0] ID_D   = 5'd5;
  localparam logic [4:0] ID_E   = 5'd6;
  localparam logic [4:0] ID_H   = 5'd7;
  localparam logic [4:0] ID_L   = 5'd8;
  localparam logic [4:0] ID_I   = 5'd9;
  localparam logic [4:0] ID_R   = 5'd10;
  localparam logic [4:0] ID_AF  = 5'd11;
  localparam logic [4:0] ID_BC  = 5'd12;
  localparam logic [4:0] ID_DE  = 5'd13;
  localparam logic [4:0] ID_HL  = 5'd14;
  localparam logic [4:0] ID_SP  = 5'd15;
  localparam logic [4:0] ID_IX  = 5'd16;
  localparam logic [4:0] ID_IY  = 5'd17;
  localparam logic [4:0] ID_T0  = 5'd18;
  localparam logic [4:0] ID_T1  = 5'd19;
  localparam logic [4:0] ID_T2  = 5'd20;
  localparam logic [4:0] ID_T3  = 5'd21;
  localparam logic [4:0] ID_AFS = 5'd22;
  localparam logic [4:0] ID_BCS = 5'd23;
  localparam logic [4:0] ID_DES = 5'd24;
  localparam logic [4:0] ID_HLS = 5'd25;

  // Pairs are stored {high, low}; index is the physical bank.
  logic [15:0] r_af [2];
  logic [15:0] r_bc [2];
  logic [15:0] r_de [2];
  logic [15:0] r_hl [2];
  logic [7:0]  r_i;
  logic [7:0]  r_r;
  logic [15:0] r_sp;
  logic [15:0] r_ix;
  logic [15:0] r_iy;
  logic [15:0] r_t [4];
  logic        r_bank_af;
  logic        r_bank_main;

  logic [15:0] w_af [2];
  logic [15:0] w_bc [2];
  logic [15:0] w_de [2];
  logic [15:0] w_hl [2];
  logic [7:0]  w_i;
  logic [7:0]  w_r;
  logic [15:0] w_sp;
  logic [15:0] w_ix;
  logic [15:0] w_iy;
  logic [15:0] w_t [4];

  logic [15:0] w_s_af [2];
  logic [15:0] w_s_bc [2];
  logic [15:0] w_s_de [2];
  logic [15:0] w_s_hl [2];
  logic [7:0]  w_s_i;
  logic [7:0]  w_s_r;
  logic [15:0] w_s_sp;
  logic [15:0] w_s_ix;
  logic [15:0] w_s_iy;
  logic [15:0] w_s_t [4];

  logic [15:0] w_view [32];
  logic        w_ba;
  logic        w_bm;
  logic        w_na;
  logic        w_nm;
  logic        w_fwd;
  logic        w_r_inc_en;

  assign w_ba = r_bank_af;
  assign w_bm = r_bank_main;
  assign w_na = ~r_bank_af;
  assign w_nm = ~r_bank_main;

`ifdef RF_BYPASS_EN
  assign w_fwd = i_rst_n;
`else
  assign w_fwd = 1'b0;
`endif

  assign w_r_inc_en = i_r_inc && !(i_wr_en && (i_wr_id == ID_R));

  function automatic logic [15:0] sx8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  // Post-merge, post-write state: what commits at the edge before R_inc/exchanges.
  always_comb begin
    w_af = r_af;
    w_bc = r_bc;
    w_de = r_de;
    w_hl = r_hl;
    w_i  = r_i;
    w_r  = r_r;
    w_sp = r_sp;
    w_ix = r_ix;
    w_iy = r_iy;
    w_t  = r_t;
    w_af[w_ba][7:0] = (r_af[w_ba][7:0] & ~i_fmask) | (i_f_data & i_fmask);
    if (i_wr_en) begin
      case (i_wr_id)
        ID_A:    w_af[w_ba][15:8] = i_wr_data[7:0];
        ID_F:    w_af[w_ba][7:0]  = i_wr_data[7:0];
        ID_B:    w_bc[w_bm][15:8] = i_wr_data[7:0];
        ID_C:    w_bc[w_bm][7:0]  = i_wr_data[7:0];
        ID_D:    w_de[w_bm][15:8] = i_wr_data[7:0];
        ID_E:    w_de[w_bm][7:0]  = i_wr_data[7:0];
        ID_H:    w_hl[w_bm][15:8] = i_wr_data[7:0];
        ID_L:    w_hl[w_bm][7:0]  = i_wr_data[7:0];
        ID_I:    w_i              = i_wr_data[7:0];
        ID_R:    w_r              = i_wr_data[7:0];
        ID_AF:   w_af[w_ba]       = i_wr_data;
        ID_BC:   w_bc[w_bm]       = i_wr_data;
        ID_DE:   w_de[w_bm]       = i_wr_data;
        ID_HL:   w_hl[w_bm]       = i_wr_data;
        ID_SP:   w_sp             = i_wr_data;
        ID_IX:   w_ix             = i_wr_data;
        ID_IY:   w_iy             = i_wr_data;
        ID_T0:   w_t[0]           = i_wr_data;
        ID_T1:   w_t[1]           = i_wr_data;
        ID_T2:   w_t[2]           = i_wr_data;
        ID_T3:   w_t[3]           = i_wr_data;
        ID_AFS:  w_af[w_na]       = i_wr_data;
        ID_BCS:  w_bc[w_nm]       = i_wr_data;
        ID_DES:  w_de[w_nm]       = i_wr_data;
        ID_HLS:  w_hl[w_nm]       = i_wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    if (w_fwd) begin
      w_s_af = w_af;
      w_s_bc = w_bc;
      w_s_de = w_de;
      w_s_hl = w_hl;
      w_s_i  = w_i;
      w_s_r  = w_r;
      w_s_sp = w_sp;
      w_s_ix = w_ix;
      w_s_iy = w_iy;
      w_s_t  = w_t;
    end else begin
      w_s_af = r_af;
      w_s_bc = r_bc;
      w_s_de = r_de;
      w_s_hl = r_hl;
      w_s_i  = r_i;
      w_s_r  = r_r;
      w_s_sp = r_sp;
      w_s_ix = r_ix;
      w_s_iy = r_iy;
      w_s_t  = r_t;
    end
  end

  // Read view indexed by register id; unused ids stay zero.
  always_comb begin
    w_view         = '{default: 16'h0000};
    w_view[ID_R0]  = 16'h0000;
    w_view[ID_A]   = sx8(w_s_af[w_ba][15:8]);
    w_view[ID_F]   = sx8(w_s_af[w_ba][7:0]);
    w_view[ID_B]   = sx8(w_s_bc[w_bm][15:8]);
    w_view[ID_C]   = sx8(w_s_bc[w_bm][7:0]);
    w_view[ID_D]   = sx8(w_s_de[w_bm][15:8]);
    w_view[ID_E]   = sx8(w_s_de[w_bm][7:0]);
    w_view[ID_H]   = sx8(w_s_hl[w_bm][15:8]);
    w_view[ID_L]   = sx8(w_s_hl[w_bm][7:0]);
    w_view[ID_I]   = sx8(w_s_i);
    w_view[ID_R]   = sx8(w_s_r);
    w_view[ID_AF]  = w_s_af[w_ba];
    w_view[ID_BC]  = w_s_bc[w_bm];
    w_view[ID_DE]  = w_s_de[w_bm];
    w_view[ID_HL]  = w_s_hl[w_bm];
    w_view[ID_SP]  = w_s_sp;
    w_view[ID_IX]  = w_s_ix;
    w_view[ID_IY]  = w_s_iy;
    w_view[ID_T0]  = w_s_t[0];
    w_view[ID_T1]  = w_s_t[1];
    w_view[ID_T2]  = w_s_t[2];
    w_view[ID_T3]  = w_s_t[3];
    w_view[ID_AFS] = w_s_af[w_na];
    w_view[ID_BCS] = w_s_bc[w_nm];
    w_view[ID_DES] = w_s_de[w_nm];
    w_view[ID_HLS] = w_s_hl[w_nm];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign o_rd_data[16*k +: 16] = w_view[i_rd_id[5*k +: 5]];
  end

  assign o_bank_af   = r_bank_af;
  assign o_bank_main = r_bank_main;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_af        <= '{default: 16'h0040};
      r_bc        <= '{default: 16'h0000};
      r_de        <= '{default: 16'h0000};
      r_hl        <= '{default: 16'h0000};
      r_i         <= 8'h00;
      r_r         <= 8'h00;
      r_sp        <= SP_RESET;
      r_ix        <= IDX_RESET;
      r_iy        <= IDX_RESET;
      r_t         <= '{default: 16'h0000};
      r_bank_af   <= 1'b0;
      r_bank_main <= 1'b0;
    end else begin
      r_af <= w_af;
      r_bc <= w_bc;
      r_de <= w_de;
      r_hl <= w_hl;
      r_i  <= w_i;
      r_r  <= w_r_inc_en ? {w_r[7], w_r[6:0] + 7'd1} : w_r;
      r_sp <= w_sp;
      r_ix <= w_ix;
      r_iy <= w_iy;
      r_t  <= w_t;
      // EX DE,HL acts on the post-write pair of the bank active before any EXX toggle.
      if (i_ex_dehl) begin
        r_de[w_bm] <= w_hl[w_bm];
        r_hl[w_bm] <= w_de[w_bm];
      end
      r_bank_af   <= r_bank_af ^ i_swap_af;
      r_bank_main <= r_bank_main ^ i_swap_main;
    end
  end

endmodule
